cpu16_bus_arbiter: RTL

- Shares the single 16-bit memory bus between the CPU16 core and NREQ auxiliary bus masters, for example a video fetcher or a DMA engine.
- Uses the core's existing hold/busy handshake to park the CPU in its opcode-select state, grants the bus to one requester for a bounded burst, then returns the bus to the CPU for a guaranteed minimum slot.
- Sits between the CPU, the requesters and the RAM. Read data goes straight from RAM to all masters; this block only muxes address, write data and write strobe, and generates handshakes.

---
 rtl/cpu16_bus_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cpu16_bus_arbiter.sv
// Shares the CPU16 memory bus with NREQ auxiliary masters: parks the CPU through hold/busy,
// grants one requester a bounded burst, then guarantees the CPU a minimum slot. rvalid lags read acks by RAM_LAT.
module cpu16_bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 8,
    parameter int CPU_SLOT  = 4,
    parameter int RAM_LAT   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    output logic                 o_cpu_hold,
    input  logic                 i_cpu_busy,
    input  logic [15:0]          i_cpu_address,
    input  logic [15:0]          i_cpu_data_out,
    input  logic                 i_cpu_write,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ-1:0]      i_req_we,
    input  logic [16*NREQ-1:0]   i_req_addr,
    input  logic [16*NREQ-1:0]   i_req_wdata,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_ack,
    output logic [NREQ-1:0]      o_rvalid,
    output logic [15:0]          o_mem_address,
    output logic [15:0]          o_mem_wdata,
    output logic                 o_mem_write
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(CPU_SLOT + 1);

    typedef enum logic [1:0] {S_CPU, S_HOLD, S_GRANT, S_RELEASE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_hold, w_hold_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]   r_g, w_g_nxt;
    logic [IW-1:0]   r_rr, w_rr_nxt;
    logic [SW-1:0]   r_slot, w_slot_nxt;
    logic [7:0]      r_burst, w_burst_nxt;
    logic [RAM_LAT-1:0] r_rv_vld;
    logic [IW-1:0]   r_rv_idx [RAM_LAT];

    logic [15:0]     w_addr  [NREQ];
    logic [15:0]     w_wdata [NREQ];
    logic [IW-1:0]   w_pick, w_cand;
    logic            w_pick_vld;
    logic            w_any_req, w_sel_req, w_sel_we, w_acc, w_push;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign w_addr[gi]  = i_req_addr[16*gi +: 16];
        assign w_wdata[gi] = i_req_wdata[16*gi +: 16];
    end

    assign w_any_req = |i_req;
    assign w_sel_req = i_req[r_g];
    assign w_sel_we  = i_req_we[r_g];
    assign w_acc     = (r_state == S_GRANT) && w_sel_req;
    assign w_push    = w_acc && !w_sel_we;

    // Round-robin: first requester at or after r_rr, wrapping.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IW'((int'(r_rr) + k) % NREQ);
            if (!w_pick_vld && i_req[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_gnt_nxt     = r_gnt;
        w_g_nxt       = r_g;
        w_rr_nxt      = r_rr;
        w_slot_nxt    = r_slot;
        w_burst_nxt   = r_burst;
        o_mem_address = i_cpu_address;
        o_mem_wdata   = i_cpu_data_out;
        o_mem_write   = i_cpu_write;
        o_ack         = '0;
        case (r_state)
            S_CPU: begin
                if (r_slot != '0) w_slot_nxt = r_slot - 1'b1;
                if (r_slot == '0 && w_any_req) begin
                    w_hold_nxt  = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_cpu_busy) begin
                    if (w_pick_vld) begin
                        w_g_nxt     = w_pick;
                        w_gnt_nxt   = NREQ'(1) << w_pick;
                        w_burst_nxt = 8'(MAX_BURST);
                        w_state_nxt = S_GRANT;
                    end else begin
                        w_hold_nxt  = 1'b0;
                        w_state_nxt = S_RELEASE;
                    end
                end
            end
            S_GRANT: begin
                o_mem_address = w_addr[r_g];
                o_mem_wdata   = w_wdata[r_g];
                o_mem_write   = w_sel_req & w_sel_we;
                o_ack         = w_acc ? (NREQ'(1) << r_g) : '0;
                if (w_acc) w_burst_nxt = r_burst - 8'd1;
                // A dropped request and the final counted access leave through the same exit.
                if (!w_sel_req || r_burst == 8'd1) begin
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = 1'b0;
                    w_rr_nxt    = (r_g == IW'(NREQ - 1)) ? '0 : r_g + 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                o_mem_write = 1'b0;
                w_slot_nxt  = SW'(CPU_SLOT);
                w_state_nxt = S_CPU;
            end
            default: w_state_nxt = S_CPU;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_CPU;
            r_hold  <= 1'b0;
            r_gnt   <= '0;
            r_g     <= '0;
            r_rr    <= '0;
            r_slot  <= SW'(CPU_SLOT);
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
            r_g     <= w_g_nxt;
            r_rr    <= w_rr_nxt;
            r_slot  <= w_slot_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rv_vld <= '0;
            for (int k = 0; k < RAM_LAT; k++) r_rv_idx[k] <= '0;
        end else begin
            r_rv_vld[0] <= w_push;
            r_rv_idx[0] <= r_g;
            for (int k = 1; k < RAM_LAT; k++) begin
                r_rv_vld[k] <= r_rv_vld[k-1];
                r_rv_idx[k] <= r_rv_idx[k-1];
            end
        end
    end

    assign o_rvalid   = r_rv_vld[RAM_LAT-1] ? (NREQ'(1) << r_rv_idx[RAM_LAT-1]) : '0;
    assign o_cpu_hold = r_hold;
    assign o_gnt      = r_gnt;

endmodule
